bpb_table: RTL
==============

# bpb_table

Parametrised branch prediction buffer for the fetch stage. It holds `ENTRIES` direct-mapped entries, each with a valid bit, a tag and a saturating counter of `CTR_WIDTH` bits. It answers one registered lookup per cycle and accepts one training update per cycle from the resolve stage. It replaces the per-entry 2-bit units with a single indexed array that has configurable counter width, a global invalidate, and same-cycle update-to-lookup forwarding.

## Interface
- `ENTRIES`, 64: number of entries; must be a power of two, ≥2.
- `TAG_WIDTH`, 10: tag bits stored per entry.
- `CTR_WIDTH`, 2: saturating counter width, ≥1. The prediction is the counter MSB.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  freezes lookup output registers and blocks updates.
- `flush`  in  1  kills the in-flight prediction.
- `clear`  in  1  invalidates all entries.
- `lookup_valid`  in  1  lookup request.
- `lookup_pc`  in  32  fetch PC.
- `pred_valid`  out  1  prediction present.
- `pred_hit`  out  1  tag matched a valid entry.
- `pred_taken`  out  1  predicted direction; 0 on a miss.
- `upd_valid`  in  1  training request.
- `upd_pc`  in  32  resolved branch PC.
- `upd_mode`  in  1  1 = direction training, 0 = mistake training.
- `upd_taken`  in  1  actual direction (direction mode).
- `upd_mistake`  in  1  prediction was wrong (mistake mode).

## Operation
- **Address split:** `IW = $clog2(ENTRIES)`.
  - Index = `pc[IW+1:2]`.
  - Tag = `pc[IW+TAG_WIDTH+1:IW+2]`.
- **Update.** An update occurs when `upd_valid & !stall & !clear`.
  - **Allocation:** if the entry is invalid or its tag differs, the entry is first reset: tag ← new tag, counter ← 0, valid ← 1. The step below is then applied to that reset counter.
  - **Direction mode:** taken → counter +1, saturating at all-ones. Not-taken → counter −1, saturating at 0.
  - **Mistake mode:** if `upd_mistake`, the counter moves one step toward the opposite of its MSB: MSB=1 → −1, MSB=0 → +1. Otherwise it moves one step toward its MSB (strengthen). Both directions saturate.
- **Lookup.** When `lookup_valid & !stall`, the registered outputs load on the next edge:
  - `pred_valid` ← 1.
  - `pred_hit` ← valid & tag match.
  - `pred_taken` ← hit & counter MSB.
- **Forwarding:** a lookup to the same index as a concurrent update sees the post-update entry, including allocation.
- **Flush:** `flush` (not stalled) clears `pred_valid`, `pred_hit` and `pred_taken` on the next edge. Flush has priority over a concurrent lookup. The table itself is unchanged.
- **Clear:** `clear` invalidates every entry on the next edge, regardless of `stall`. A concurrent update is dropped. A concurrent lookup reports a miss.
- **Reset:** all valid bits, tags, counters and outputs go to 0 immediately. Reset may arrive mid-stream; nothing survives it.
- **No lookup:** with `lookup_valid`=0 and no stall, `pred_valid` ← 0 on the next edge.

## Timing
- Lookup latency: 1 cycle (request at edge N → outputs valid after edge N+1).
- Update latency: 1 cycle. The entry is visible to a lookup issued in the same cycle via forwarding, and visible in the array from edge N+1.
- `stall` holds all output registers and the array. `clear` and `reset` override `stall`.
- Priority, highest first: `reset` > `clear` > `stall` > `flush` > lookup/update.

## Structure
- Package `bpb_pkg`:
  - Default parameter constants.
  - `upd_mode_e` enum: `MODE_MISTAKE` = 0, `MODE_DIRECTION` = 1.
  - Function `sat_step(ctr, up)` for saturating increment/decrement.
- Sub-module `bpb_ctr_next`: combinational next-counter logic, taking the old counter, mode, taken, mistake and an allocate flag. It is instantiated once, on the update path. Its result feeds both the array write and the forwarding mux.
- The array is implemented as flop vectors, because `clear` and `reset` must act on all entries at once.

## Test plan
- **Reset then lookup:** reset, then lookup PC `0x0000_1000` → `pred_valid`=1, `pred_hit`=0, `pred_taken`=0.
- **Allocation and saturation:**
  - Update `0x1000` in direction mode, taken → counter 01.
  - Second taken update → 10; a lookup now gives `hit`=1, `taken`=1.
  - Third and fourth taken updates → 11, held.
  - Not-taken → 10.
- **Tag conflict:** train `0x1000` to 11. Update `0x1000 + (ENTRIES×4)`, taken → entry retagged, counter 01. A lookup of `0x1000` now misses.
- **Mistake mode:** from counter 11, `upd_mistake`=1 → 10. `upd_mistake`=1 again → 01, and `pred_taken` becomes 0. `upd_mistake`=0 → 00.
- **Forwarding:** in the same cycle, update an empty index with taken (allocate → 01) and look up the same PC. Next cycle: `hit`=1, `taken`=0. Repeat from 01: same-cycle taken update plus lookup → `taken`=1.
- **Control:**
  - With `stall`=1 for 3 cycles, outputs hold and the counter does not change.
  - `flush` with a concurrent lookup → `pred_valid`=0.
  - `clear` with a concurrent update → all subsequent lookups miss.

Source files
------------

// File: rtl/bpb_pkg.sv
// Shared constants, update-mode encoding and the saturating step used by the
// branch prediction buffer.
package bpb_pkg;

    localparam int DEF_ENTRIES   = 64;
    localparam int DEF_TAG_WIDTH = 10;
    localparam int DEF_CTR_WIDTH = 2;
    // Widest counter sat_step can handle; callers zero-extend into this width.
    localparam int CTR_MAX_W     = 8;

    typedef enum logic {
        MODE_MISTAKE   = 1'b0,
        MODE_DIRECTION = 1'b1
    } upd_mode_e;

    function automatic logic [CTR_MAX_W-1:0] sat_step(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 up,
        input logic [CTR_MAX_W-1:0] max_val
    );
        if (up)
            return (ctr == max_val) ? ctr : ctr + CTR_MAX_W'(1);
        else
            return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/bpb_table_if.sv
// Lookup, prediction, training and control signals between fetch/resolve and
// the branch prediction buffer.
interface bpb_table_if;
    logic        stall;
    logic        flush;
    logic        clear;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_mode;
    logic        upd_taken;
    logic        upd_mistake;

    modport master (
        output stall, flush, clear, lookup_valid, lookup_pc,
               upd_valid, upd_pc, upd_mode, upd_taken, upd_mistake,
        input  pred_valid, pred_hit, pred_taken
    );

    modport slave (
        input  stall, flush, clear, lookup_valid, lookup_pc,
               upd_valid, upd_pc, upd_mode, upd_taken, upd_mistake,
        output pred_valid, pred_hit, pred_taken
    );
endinterface

// File: rtl/bpb_ctr_next.sv
// Next-state counter for one training update; an allocating update starts
// from a zero counter before the step is applied.
module bpb_ctr_next
    import bpb_pkg::*;
#(
    parameter int CTR_WIDTH = DEF_CTR_WIDTH
) (
    input  logic [CTR_WIDTH-1:0] ctr_i,
    input  upd_mode_e            mode_i,
    input  logic                 taken_i,
    input  logic                 mistake_i,
    input  logic                 alloc_i,
    output logic [CTR_WIDTH-1:0] ctr_o
);

    logic [CTR_WIDTH-1:0] base;
    logic                 up;
    logic [CTR_MAX_W-1:0] stepped;
    logic                 unused_stepped;

    always_comb begin
        base = alloc_i ? '0 : ctr_i;
        up   = taken_i;
        // Mistake weakens toward the opposite of the MSB, otherwise strengthen.
        if (mode_i == MODE_MISTAKE)
            up = mistake_i ? ~base[CTR_WIDTH-1] : base[CTR_WIDTH-1];
        stepped = sat_step(CTR_MAX_W'(base), up, CTR_MAX_W'({CTR_WIDTH{1'b1}}));
        ctr_o   = stepped[CTR_WIDTH-1:0];
    end

    assign unused_stepped = ^stepped;

endmodule

// File: rtl/bpb_table.sv
// Direct-mapped branch prediction buffer: one registered lookup and one
// training update per cycle, with update-to-lookup forwarding and global clear.
module bpb_table
    import bpb_pkg::*;
#(
    parameter int ENTRIES   = DEF_ENTRIES,
    parameter int TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int CTR_WIDTH = DEF_CTR_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    bpb_table_if.slave  bus
);

    localparam int IW = $clog2(ENTRIES);

    logic                 valid_q [ENTRIES];
    logic [TAG_WIDTH-1:0] tag_q   [ENTRIES];
    logic [CTR_WIDTH-1:0] ctr_q   [ENTRIES];

    logic [IW-1:0]        upd_idx, lk_idx;
    logic [TAG_WIDTH-1:0] upd_tag, lk_tag;
    logic                 upd_en, upd_alloc;
    logic [CTR_WIDTH-1:0] upd_ctr;
    logic                 unused_pc;

    assign upd_idx   = bus.upd_pc[IW+1:2];
    assign upd_tag   = bus.upd_pc[IW+TAG_WIDTH+1:IW+2];
    assign lk_idx    = bus.lookup_pc[IW+1:2];
    assign lk_tag    = bus.lookup_pc[IW+TAG_WIDTH+1:IW+2];
    assign unused_pc = ^{bus.upd_pc, bus.lookup_pc};

    assign upd_en    = bus.upd_valid & ~bus.stall & ~bus.clear;
    assign upd_alloc = ~valid_q[upd_idx] | (tag_q[upd_idx] != upd_tag);

    bpb_ctr_next #(.CTR_WIDTH(CTR_WIDTH)) u_ctr_next (
        .ctr_i     (ctr_q[upd_idx]),
        .mode_i    (upd_mode_e'(bus.upd_mode)),
        .taken_i   (bus.upd_taken),
        .mistake_i (bus.upd_mistake),
        .alloc_i   (upd_alloc),
        .ctr_o     (upd_ctr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= '0;
            end
        end else if (bus.clear) begin
            for (int i = 0; i < ENTRIES; i++)
                valid_q[i] <= 1'b0;
        end else if (upd_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            ctr_q[upd_idx]   <= upd_ctr;
        end
    end

    // Lookup path: a same-index update is visible to this lookup already.
    logic                 lk_fwd, lk_hit;
    logic                 lk_entry_valid;
    logic [TAG_WIDTH-1:0] lk_entry_tag;
    logic [CTR_WIDTH-1:0] lk_entry_ctr;
    logic                 pred_valid_q, pred_hit_q, pred_taken_q;
    logic                 pred_valid_d, pred_hit_d, pred_taken_d;

    always_comb begin
        lk_fwd         = upd_en && (upd_idx == lk_idx);
        lk_entry_valid = lk_fwd ? 1'b1    : valid_q[lk_idx];
        lk_entry_tag   = lk_fwd ? upd_tag : tag_q[lk_idx];
        lk_entry_ctr   = lk_fwd ? upd_ctr : ctr_q[lk_idx];
        lk_hit         = lk_entry_valid && (lk_entry_tag == lk_tag) && !bus.clear;

        pred_valid_d = pred_valid_q;
        pred_hit_d   = pred_hit_q;
        pred_taken_d = pred_taken_q;
        if (!bus.stall) begin
            pred_valid_d = bus.lookup_valid & ~bus.flush;
            pred_hit_d   = pred_valid_d & lk_hit;
            pred_taken_d = pred_hit_d & lk_entry_ctr[CTR_WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_hit_q   <= pred_hit_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_hit   = pred_hit_q;
    assign bus.pred_taken = pred_taken_q;

endmodule
